// File: rtl/vga_sprite_arbiter.sv
// Four-sprite pixel arbiter for the VGA datapath. Sprite updates land in shadow
// registers and are committed to the active set once per frame at the vsync rise.
module vga_sprite_arbiter #(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] curr_x,
  input  logic [9:0]  curr_y,
  input  logic        vsync,
  input  logic [11:0] bg_color,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [1:0]  upd_idx,
  input  logic [10:0] upd_x,
  input  logic [9:0]  upd_y,
  input  logic [11:0] upd_color,
  input  logic        upd_en,
  output logic [3:0]  red_out,
  output logic [3:0]  gre_out,
  output logic [3:0]  blu_out,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  typedef enum logic {RUN, COMMIT} state_t;

  state_t      state;
  logic        vsync_d;
  logic [10:0] sh_x      [4];
  logic [9:0]  sh_y      [4];
  logic [11:0] sh_color  [4];
  logic        sh_en     [4];
  logic [10:0] act_x     [4];
  logic [9:0]  act_y     [4];
  logic [11:0] act_color [4];
  logic        act_en    [4];
  logic [3:0]  hit;
  logic [11:0] pix_next;

  assign upd_ready = (state == RUN);

  // Right/bottom bounds are one bit wider than the coordinates so sprites near
  // the screen edge are clipped instead of wrapping back to column/line 0.
  always_comb begin
    hit = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = act_en[i]
             & (curr_x >= act_x[i])
             & ({1'b0, curr_x} < ({1'b0, act_x[i]} + 12'(SPR_W)))
             & (curr_y >= act_y[i])
             & ({1'b0, curr_y} < ({1'b0, act_y[i]} + 11'(SPR_H)));
    end
  end

  always_comb begin
    pix_next = bg_color;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) pix_next = act_color[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        sh_x[i]     <= '0;
        sh_y[i]     <= '0;
        sh_color[i] <= '0;
        sh_en[i]    <= 1'b0;
      end
    end else if (upd_valid && upd_ready) begin
      sh_x[upd_idx]     <= upd_x;
      sh_y[upd_idx]     <= upd_y;
      sh_color[upd_idx] <= upd_color;
      sh_en[upd_idx]    <= upd_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      vsync_d    <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      red_out    <= '0;
      gre_out    <= '0;
      blu_out    <= '0;
      for (int i = 0; i < 4; i++) begin
        act_x[i]     <= '0;
        act_y[i]     <= '0;
        act_color[i] <= '0;
        act_en[i]    <= 1'b0;
      end
    end else begin
      vsync_d    <= vsync;
      frame_tick <= 1'b0;
      red_out    <= pix_next[11:8];
      gre_out    <= pix_next[7:4];
      blu_out    <= pix_next[3:0];
      case (state)
        RUN: begin
          if (vsync && !vsync_d) state <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < 4; i++) begin
            act_x[i]     <= sh_x[i];
            act_y[i]     <= sh_y[i];
            act_color[i] <= sh_color[i];
            act_en[i]    <= sh_en[i];
          end
          frame_tick <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
          state      <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
